fcvt_pipe: RTL and testbench
============================

# fcvt_pipe

Pipelined, parametrised float/integer converter for the FPU: IEEE 754 single precision to signed/unsigned INT_W-bit integer and back. It adds to the existing combinational converter:
- a valid/ready handshake with a 2-stage pipeline;
- full rounding-mode support;
- NaN/Inf/overflow saturation;
- exception flags.

It sits between the FPU operand issue logic and the FPU writeback arbiter.

## Interface
- INT_W, 32, integer width; legal values 32 or 64.
- clk_i  input  1  clock, rising edge.
- rst_ni  input  1  asynchronous, active-low reset.
- valid_i  input  1  request valid.
- ready_o  output  1  request accepted when valid_i && ready_o.
- a_i  input  INT_W  operand; float operations use a_i[31:0] and ignore the upper bits.
- op_signed_i  input  1  1 = signed integer side, 0 = unsigned.
- conv_type_i  input  1  1 = int→float, 0 = float→int.
- rm_i  input  3  rounding mode: 000 RNE, 001 RTZ, 010 RDN, 011 RUP, 100 RMM; 101–111 behave as RNE.
- valid_o  output  1  result valid.
- ready_i  input  1  downstream accepts when valid_o && ready_i.
- result_o  output  INT_W  result; a float result is zero-extended.
- flags_o  output  5  {NV, DZ, OF, UF, NX}; DZ, OF and UF are always 0.

## Operation
- Stage 1 (S1):
  - unpack and classify: zero, denormal, normal, Inf, NaN;
  - int→float: take the magnitude (two's complement if op_signed_i and MSB set), then leading-zero count and left-normalise;
  - float→int: align the significand by exp−127 into an INT_W+2-bit field plus a sticky bit;
  - register all fields.
- Stage 2 (S2): round, saturate, pack, register into result_o/flags_o.
- Rounding increment uses lsb, guard, sticky, sign and rm. A rounding carry in int→float bumps the exponent (mantissa becomes 0).
- float→int rules:
  - Denormals and |x|<1 are rounded per rm, not flushed; e.g. +denormal with RUP gives 1.
  - NaN → signed 2^(INT_W−1)−1, unsigned all-ones; NV.
  - +Inf, or rounded value above the range maximum → signed max, unsigned all-ones; NV.
  - −Inf, or rounded value below the range minimum → signed min, unsigned 0; NV.
  - Unsigned negative input whose rounded value ≠ 0 → 0, NV.
  - Unsigned negative input rounding to 0 → 0, NX only.
  - Otherwise NX = (guard|sticky).
- int→float rules:
  - 0 → 0x00000000, no flags.
  - NX when any discarded bit is nonzero.
  - Overflow is impossible for INT_W ≤ 64.
- NV and NX are mutually exclusive.

## Timing
- Latency: 2 cycles from acceptance to valid_o, with ready_i held high.
- Throughput: 1 operation per cycle.
- Handshake:
  - S2 loads when !valid_o || ready_i.
  - S1 loads when S1 is empty or S2 loads.
  - ready_o = !s1_valid || s2_load; this is a combinational path from ready_i, which is permitted.
- Stall: valid_o, result_o and flags_o are held stable while valid_o && !ready_i.
- Flow:
  - No drops or duplicates.
  - Results leave in acceptance order.
  - Bubbles collapse.
- Reset:
  - valid_o=0, result_o=0, flags_o=0, internal valids=0.
  - ready_o=1 while in reset and in the first cycle after reset.
- Reset mid-operation: in-flight operations are discarded and no result emerges after release.
- Inputs are sampled only on acceptance; changes while !ready_o have no effect.

## Configuration
- FCVT_ROUND_EN defined: all rounding modes are implemented as specified.
- FCVT_ROUND_EN undefined:
  - rm_i is ignored and all operations round toward zero (RTZ);
  - NX and NV are still reported;
  - the RMM/RNE tie logic is removed.

## Structure
- Package fcvt_pkg holds:
  - rounding-mode enum and flag bit-index constants;
  - float field constants: bias 127, exponent 8 bits, mantissa 23 bits;
  - canonical constants: quiet NaN 0x7FC00000, signed max/min per INT_W.
- Sub-module fcvt_round is a combinational round-increment decision:
  - inputs: sign, lsb, guard, sticky, rm;
  - output: increment;
  - it is instantiated once in S2.

## Test plan
- Rounding, float→int, INT_W=32, signed:
  - 0x3FC00000 (1.5), RNE → 0x00000002, NX.
  - Same input, RTZ → 0x00000001, NX.
  - 0xBFC00000 (−1.5), RDN → 0xFFFFFFFE, NX.
- Special cases, INT_W=32:
  - 0x7FC00000, signed → 0x7FFFFFFF, NV.
  - 0xBF800000 (−1.0), unsigned → 0x0, NV.
  - 0xBE99999A (−0.3), unsigned, RTZ → 0x0, NX only.
- Saturation, INT_W=64, input 0x5F000000 (2^63):
  - signed → 0x7FFF_FFFF_FFFF_FFFF, NV.
  - unsigned → 0x8000_0000_0000_0000, no flags.
- int→float:
  - 0x01000001, unsigned, RNE → 0x4B800000, NX.
  - Same input, RUP → 0x4B800001, NX.
  - 0x80000000, signed → 0xCF000000, no flags.
  - 0 → 0x00000000.
- Handshake:
  - 16 back-to-back requests with ready_i randomly toggled: outputs in order, none lost or duplicated.
  - With ready_i held high: latency exactly 2, and outputs stay stable throughout each stall.
- Reset:
  - Assert rst_ni low with 2 operations in flight: valid_o drops at once, and no valid_o appears after release until new input.

Source files
------------

// File: rtl/fcvt_pkg.sv
// Shared types and constants for the float/integer converter.
package fcvt_pkg;

  typedef enum logic [2:0] {
    RM_RNE = 3'b000,
    RM_RTZ = 3'b001,
    RM_RDN = 3'b010,
    RM_RUP = 3'b011,
    RM_RMM = 3'b100
  } rm_e;

  // Bit positions inside flags_o = {NV, DZ, OF, UF, NX}
  localparam int unsigned FLAG_NV = 4;
  localparam int unsigned FLAG_DZ = 3;
  localparam int unsigned FLAG_OF = 2;
  localparam int unsigned FLAG_UF = 1;
  localparam int unsigned FLAG_NX = 0;

  localparam int unsigned F_BIAS  = 127;
  localparam int unsigned F_EXP_W = 8;
  localparam int unsigned F_MAN_W = 23;

  localparam logic [31:0] F_QNAN  = 32'h7FC0_0000;

  localparam logic [63:0] SMAX_32 = 64'h0000_0000_7FFF_FFFF;
  localparam logic [63:0] SMIN_32 = 64'h0000_0000_8000_0000;
  localparam logic [63:0] SMAX_64 = 64'h7FFF_FFFF_FFFF_FFFF;
  localparam logic [63:0] SMIN_64 = 64'h8000_0000_0000_0000;

endpackage

// File: rtl/fcvt_round.sv
// Round-increment decision from sign/lsb/guard/sticky and rounding mode.
// Without FCVT_ROUND_EN every operation truncates (RTZ).
module fcvt_round
  import fcvt_pkg::*;
(
  input  logic i_sign,
  input  logic i_lsb,
  input  logic i_guard,
  input  logic i_sticky,
  input  rm_e  i_rm,
  output logic o_inc
);

`ifdef FCVT_ROUND_EN
  always_comb begin
    o_inc = 1'b0;
    case (i_rm)
      RM_RTZ:  o_inc = 1'b0;
      RM_RDN:  o_inc = i_sign & (i_guard | i_sticky);
      RM_RUP:  o_inc = !i_sign & (i_guard | i_sticky);
      RM_RMM:  o_inc = i_guard;
      default: o_inc = i_guard & (i_lsb | i_sticky);
    endcase
  end
`else
  logic w_unused;
  assign w_unused = ^{i_sign, i_lsb, i_guard, i_sticky, i_rm};
  assign o_inc    = 1'b0;
`endif

endmodule

// File: rtl/fcvt_pipe.sv
// Two-stage valid/ready float<->integer converter (single precision, INT_W = 32/64).
// Optional FCVT_ROUND_EN enables all rounding modes; otherwise RTZ only.
module fcvt_pipe
  import fcvt_pkg::*;
#(
  parameter int unsigned INT_W = 32
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             valid_i,
  output logic             ready_o,
  input  logic [INT_W-1:0] a_i,
  input  logic             op_signed_i,
  input  logic             conv_type_i,
  input  logic [2:0]       rm_i,
  output logic             valid_o,
  input  logic             ready_i,
  output logic [INT_W-1:0] result_o,
  output logic [4:0]       flags_o
);

  localparam int unsigned FW  = INT_W + 2;
  localparam int unsigned LZW = $clog2(INT_W) + 1;
  localparam logic [FW-1:0]    LIM_S = FW'(1) << (INT_W - 1);
  localparam logic [FW-1:0]    LIM_U = FW'(1) << INT_W;
  localparam logic [INT_W-1:0] SMAX  = INT_W'((INT_W == 64) ? SMAX_64 : SMAX_32);
  localparam logic [INT_W-1:0] SMIN  = INT_W'((INT_W == 64) ? SMIN_64 : SMIN_32);

  logic               w_s2_load, w_s1_load;
  logic               w_fsign, w_exp_max, w_fnan, w_finf, w_fden, w_big;
  logic [F_EXP_W-1:0] w_fexp;
  logic [F_MAN_W-1:0] w_fman;
  logic [F_MAN_W:0]   w_sig;
  logic signed [9:0]  w_sh;
  logic [4:0]         w_rs;
  logic [47:0]        w_wide;
  logic [FW-1:0]      w_field;
  logic               w_fsticky;
  logic               w_ineg;
  logic [INT_W-1:0]   w_mag, w_norm;
  logic [LZW-1:0]     w_lzc;
  logic [F_EXP_W-1:0] w_iexp;

  logic               r_s1_valid, r_s1_conv, r_s1_signed, r_s1_sign;
  logic               r_s1_nan, r_s1_inf, r_s1_big, r_s1_sticky;
  rm_e                r_s1_rm;
  logic [FW-1:0]      r_s1_field;
  logic [INT_W-1:0]   r_s1_norm;
  logic [F_EXP_W-1:0] r_s1_exp;

  logic               w_lsb, w_guard, w_sticky, w_inc, w_inexact;
  logic [30:0]        w_fsum;
  logic [FW-1:0]      w_rnd;
  logic [INT_W-1:0]   w_res;
  logic               w_nv, w_nx;
  logic [4:0]         w_flags;

  logic               r_valid_o;
  logic [INT_W-1:0]   r_result;
  logic [4:0]         r_flags;

  assign w_s2_load = !r_valid_o || ready_i;
  assign w_s1_load = !r_s1_valid || w_s2_load;
  assign ready_o   = w_s1_load;

  assign w_fsign   = a_i[31];
  assign w_fexp    = a_i[F_MAN_W +: F_EXP_W];
  assign w_fman    = a_i[F_MAN_W-1:0];
  assign w_exp_max = (w_fexp == F_QNAN[F_MAN_W +: F_EXP_W]);
  assign w_fnan    = w_exp_max && (w_fman != '0);
  assign w_finf    = w_exp_max && (w_fman == '0);
  assign w_fden    = (w_fexp == '0);
  assign w_sig     = {!w_fden, w_fman};
  assign w_sh      = $signed({2'b00, w_fden ? 8'd1 : w_fexp}) - $signed(10'(F_BIAS));
  assign w_big     = (w_sh > $signed(10'(INT_W)));

  // Field keeps one fraction bit (guard) below the integer part; the rest folds into sticky.
  always_comb begin
    w_field   = '0;
    w_fsticky = 1'b0;
    w_rs      = '0;
    w_wide    = '0;
    if (w_sh > 10'sd22) begin
      w_field = FW'(w_sig) << 10'(w_sh - 10'sd22);
    end else begin
      w_rs      = (w_sh < -10'sd2) ? 5'd24 : 5'(10'sd22 - w_sh);
      w_wide    = {w_sig, 24'b0} >> w_rs;
      w_field   = FW'(w_wide[47:24]);
      w_fsticky = |w_wide[23:0];
    end
  end

  assign w_ineg = op_signed_i && a_i[INT_W-1];
  assign w_mag  = w_ineg ? (~a_i + INT_W'(1)) : a_i;

  always_comb begin
    w_lzc = LZW'(INT_W);
    for (int unsigned i = 0; i < INT_W; i++)
      if (w_mag[i]) w_lzc = LZW'(INT_W - 1 - i);
  end

  assign w_norm = w_mag << w_lzc;
  assign w_iexp = F_EXP_W'(F_BIAS + INT_W - 1 - 32'(w_lzc));

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_s1_valid  <= 1'b0;
      r_s1_conv   <= 1'b0;
      r_s1_signed <= 1'b0;
      r_s1_sign   <= 1'b0;
      r_s1_nan    <= 1'b0;
      r_s1_inf    <= 1'b0;
      r_s1_big    <= 1'b0;
      r_s1_sticky <= 1'b0;
      r_s1_rm     <= RM_RNE;
      r_s1_field  <= '0;
      r_s1_norm   <= '0;
      r_s1_exp    <= '0;
    end else if (w_s1_load) begin
      r_s1_valid <= valid_i;
      if (valid_i) begin
        r_s1_conv   <= conv_type_i;
        r_s1_signed <= op_signed_i;
        r_s1_sign   <= conv_type_i ? w_ineg : w_fsign;
        r_s1_nan    <= w_fnan;
        r_s1_inf    <= w_finf;
        r_s1_big    <= w_big;
        r_s1_sticky <= w_fsticky;
        r_s1_rm     <= rm_e'(rm_i);
        r_s1_field  <= w_field;
        r_s1_norm   <= w_norm;
        r_s1_exp    <= w_iexp;
      end
    end
  end

  assign w_lsb     = r_s1_conv ? r_s1_norm[INT_W-24] : r_s1_field[1];
  assign w_guard   = r_s1_conv ? r_s1_norm[INT_W-25] : r_s1_field[0];
  assign w_sticky  = r_s1_conv ? (|r_s1_norm[INT_W-26:0]) : r_s1_sticky;
  assign w_inexact = w_guard | w_sticky;

  fcvt_round u_round (
    .i_sign   (r_s1_sign),
    .i_lsb    (w_lsb),
    .i_guard  (w_guard),
    .i_sticky (w_sticky),
    .i_rm     (r_s1_rm),
    .o_inc    (w_inc)
  );

  // A mantissa carry ripples into the exponent field directly.
  assign w_fsum = {r_s1_exp, r_s1_norm[INT_W-2 -: F_MAN_W]} + 31'(w_inc);
  assign w_rnd  = {1'b0, r_s1_field[FW-1:1]} + FW'(w_inc);

  always_comb begin
    w_res = '0;
    w_nv  = 1'b0;
    w_nx  = 1'b0;
    if (r_s1_conv) begin
      if (r_s1_norm[INT_W-1]) begin
        w_res = INT_W'({r_s1_sign, w_fsum});
        w_nx  = w_inexact;
      end
    end else if (r_s1_nan) begin
      w_res = r_s1_signed ? SMAX : '1;
      w_nv  = 1'b1;
    end else if (!r_s1_sign) begin
      if (r_s1_inf || r_s1_big || (w_rnd >= (r_s1_signed ? LIM_S : LIM_U))) begin
        w_res = r_s1_signed ? SMAX : '1;
        w_nv  = 1'b1;
      end else begin
        w_res = w_rnd[INT_W-1:0];
        w_nx  = w_inexact;
      end
    end else begin
      if (r_s1_inf || r_s1_big || (r_s1_signed ? (w_rnd > LIM_S) : (w_rnd != '0))) begin
        w_res = r_s1_signed ? SMIN : '0;
        w_nv  = 1'b1;
      end else begin
        w_res = r_s1_signed ? (~w_rnd[INT_W-1:0] + INT_W'(1)) : '0;
        w_nx  = w_inexact;
      end
    end
    w_flags          = '0;
    w_flags[FLAG_NV] = w_nv;
    w_flags[FLAG_DZ] = 1'b0;
    w_flags[FLAG_OF] = 1'b0;
    w_flags[FLAG_UF] = 1'b0;
    w_flags[FLAG_NX] = w_nx;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_valid_o <= 1'b0;
      r_result  <= '0;
      r_flags   <= '0;
    end else if (w_s2_load) begin
      r_valid_o <= r_s1_valid;
      if (r_s1_valid) begin
        r_result <= w_res;
        r_flags  <= w_flags;
      end
    end
  end

  assign valid_o  = r_valid_o;
  assign result_o = r_result;
  assign flags_o  = r_flags;

endmodule

// File: tb/tb_fcvt_pipe.sv
// Directed scoreboard bench for fcvt_pipe, one instance per integer width.
module tb_fcvt_pipe;

`ifdef FCVT_ROUND_EN
  localparam bit RND = 1'b1;
`else
  localparam bit RND = 1'b0;
`endif

  localparam logic [4:0] NV = 5'b10000;
  localparam logic [4:0] NX = 5'b00001;
  localparam logic [4:0] NF = 5'b00000;

  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst_n;

  logic        v32, rdy32, sg32, ct32, vo32, ri32;
  logic [2:0]  rm32;
  logic [31:0] a32, r32;
  logic [4:0]  f32;
  logic        v64, rdy64, sg64, ct64, vo64, ri64;
  logic [2:0]  rm64;
  logic [63:0] a64, r64;
  logic [4:0]  f64;

  fcvt_pipe #(.INT_W(32)) u_d32 (
    .clk_i(clk), .rst_ni(rst_n), .valid_i(v32), .ready_o(rdy32), .a_i(a32),
    .op_signed_i(sg32), .conv_type_i(ct32), .rm_i(rm32), .valid_o(vo32),
    .ready_i(ri32), .result_o(r32), .flags_o(f32));

  fcvt_pipe #(.INT_W(64)) u_d64 (
    .clk_i(clk), .rst_ni(rst_n), .valid_i(v64), .ready_o(rdy64), .a_i(a64),
    .op_signed_i(sg64), .conv_type_i(ct64), .rm_i(rm64), .valid_o(vo64),
    .ready_i(ri64), .result_o(r64), .flags_o(f64));

  typedef struct {
    logic [63:0] res;
    logic [4:0]  fl;
    int          id;
  } exp_t;

  exp_t        q32[$], q64[$];
  int          n_cmp = 0, n_bad = 0, n_id = 0;
  bit          ps[2];
  logic [63:0] pr[2];
  logic [4:0]  pf[2];

  task automatic chk(input string tag, input int id, input logic [63:0] obs, input logic [63:0] expv);
    n_cmp++;
    assert (obs === expv) else begin
      n_bad++;
      $error("FAIL %s #%0d: observed %h expected %h", tag, id, obs, expv);
    end
  endtask

  function automatic logic [31:0] f_of_int(input int unsigned k);
    int unsigned e = 0;
    for (int unsigned i = 0; i < 32; i++) if (k[i]) e = i;
    return {1'b0, 8'(127 + e), 23'(k << (23 - e))};
  endfunction

  task automatic observe(input bit d);
    logic vo, ri;
    logic [63:0] r;
    logic [4:0] f;
    exp_t e;
    int sz;
    vo = d ? vo64 : vo32;
    ri = d ? ri64 : ri32;
    r  = d ? r64 : 64'(r32);
    f  = d ? f64 : f32;
    sz = d ? q64.size() : q32.size();
    if (ps[d]) begin
      chk("stall_valid", int'(d), 64'(vo), 64'd1);
      chk("stall_result", int'(d), r, pr[d]);
      chk("stall_flags", int'(d), 64'(f), 64'(pf[d]));
    end
    ps[d] = vo && !ri;
    pr[d] = r;
    pf[d] = f;
    if (vo && ri) begin
      n_cmp++;
      assert (sz != 0) else begin
        n_bad++;
        $error("FAIL unexpected_output dut%0d: observed result %h, expected no output", d, r);
      end
      if (sz != 0) begin
        e = d ? q64.pop_front() : q32.pop_front();
        chk("result", e.id, r, e.res);
        chk("flags", e.id, 64'(f), 64'(e.fl));
      end
    end
  endtask

  always @(negedge clk) begin
    if (!rst_n) begin
      ps[0] = 1'b0;
      ps[1] = 1'b0;
    end else begin
      observe(1'b0);
      observe(1'b1);
    end
  end

  // Called at posedge+1; returns at posedge+1 right after the accepting edge.
  task automatic send(input bit d, input logic [63:0] a, input logic sg, input logic ct,
                      input logic [2:0] rm, input logic [63:0] er, input logic [4:0] ef,
                      input bit rnd);
    bit acc;
    if (d) begin v64 = 1'b1; a64 = a; sg64 = sg; ct64 = ct; rm64 = rm; end
    else   begin v32 = 1'b1; a32 = a[31:0]; sg32 = sg; ct32 = ct; rm32 = rm; end
    for (int k = 0; k < 200; k++) begin
      @(negedge clk);
      acc = d ? rdy64 : rdy32;
      @(posedge clk);
      #1;
      if (rnd) ri32 = 1'($urandom_range(0, 1));
      if (acc) begin
        if (d) begin q64.push_back('{er, ef, n_id}); v64 = 1'b0; end
        else   begin q32.push_back('{er, ef, n_id}); v32 = 1'b0; end
        n_id++;
        return;
      end
    end
    chk("accept_timeout", n_id, 64'(acc), 64'd1);
    if (d) v64 = 1'b0; else v32 = 1'b0;
  endtask

  task automatic drain();
    ri32 = 1'b1;
    ri64 = 1'b1;
    repeat (8) @(posedge clk);
    #1;
    chk("drain32", -1, 64'(q32.size()), 64'd0);
    chk("drain64", -1, 64'(q64.size()), 64'd0);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] val;
    rst_n = 1'b0;
    v32 = 1'b0; sg32 = 1'b0; ct32 = 1'b0; rm32 = '0; a32 = '0; ri32 = 1'b1;
    v64 = 1'b0; sg64 = 1'b0; ct64 = 1'b0; rm64 = '0; a64 = '0; ri64 = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_valid32", -1, 64'(vo32), 64'd0);
    chk("rst_ready32", -1, 64'(rdy32), 64'd1);
    chk("rst_result32", -1, 64'(r32), 64'd0);
    chk("rst_flags32", -1, 64'(f32), 64'd0);
    chk("rst_valid64", -1, 64'(vo64), 64'd0);
    rst_n = 1'b1;
    chk("ready_after_rst", -1, 64'(rdy32), 64'd1);

    // float -> int, 32-bit
    send(0, 64'h3FC00000, 1, 0, 3'd0, RND ? 64'd2 : 64'd1, NX, 0);
    send(0, 64'h3FC00000, 1, 0, 3'd1, 64'd1, NX, 0);
    send(0, 64'hBFC00000, 1, 0, 3'd2, RND ? 64'hFFFFFFFE : 64'hFFFFFFFF, NX, 0);
    send(0, 64'h7FC00000, 1, 0, 3'd0, 64'h7FFFFFFF, NV, 0);
    send(0, 64'h7FC00000, 0, 0, 3'd0, 64'hFFFFFFFF, NV, 0);
    send(0, 64'hBF800000, 0, 0, 3'd0, 64'd0, NV, 0);
    send(0, 64'hBE99999A, 0, 0, 3'd1, 64'd0, NX, 0);
    send(0, 64'h00000001, 0, 0, 3'd3, RND ? 64'd1 : 64'd0, NX, 0);
    send(0, 64'hFF800000, 1, 0, 3'd0, 64'h80000000, NV, 0);
    send(0, 64'h4F800000, 0, 0, 3'd0, 64'hFFFFFFFF, NV, 0);
    send(0, 64'h4F7FFFFF, 0, 0, 3'd0, 64'hFFFFFF00, NF, 0);
    send(0, 64'h3F000000, 1, 0, 3'd0, 64'd0, NX, 0);
    send(0, 64'h3F000000, 1, 0, 3'd4, RND ? 64'd1 : 64'd0, NX, 0);
    send(0, 64'hCF000000, 1, 0, 3'd0, 64'h80000000, NF, 0);
    // int -> float, 32-bit
    send(0, 64'h01000001, 0, 1, 3'd0, 64'h4B800000, NX, 0);
    send(0, 64'h01000001, 0, 1, 3'd3, RND ? 64'h4B800001 : 64'h4B800000, NX, 0);
    send(0, 64'h80000000, 1, 1, 3'd0, 64'hCF000000, NF, 0);
    send(0, 64'h00000000, 1, 1, 3'd0, 64'h00000000, NF, 0);
    send(0, 64'h01FFFFFF, 0, 1, 3'd0, RND ? 64'h4C000000 : 64'h4BFFFFFF, NX, 0);
    send(0, 64'hFFFFFFFF, 1, 1, 3'd0, 64'hBF800000, NF, 0);
    // 64-bit instance
    send(1, 64'h5F000000, 1, 0, 3'd0, 64'h7FFFFFFFFFFFFFFF, NV, 0);
    send(1, 64'h5F000000, 0, 0, 3'd0, 64'h8000000000000000, NF, 0);
    send(1, 64'hFFFFFFFFFFFFFFFF, 0, 1, 3'd0, RND ? 64'h5F800000 : 64'h5F7FFFFF, NX, 0);
    send(1, 64'hDEADBEEF3FC00000, 1, 0, 3'd1, 64'd1, NX, 0);
    drain();

    // 16 back-to-back requests while ready_i toggles randomly
    for (int k = 0; k < 16; k++) begin
      val = $urandom_range(1, 32'h00FFFFFF);
      send(0, 64'(val), 0, 1, 3'd0, 64'(f_of_int(val)), NF, 1);
    end
    drain();

    // latency with ready_i high
    send(0, 64'h40400000, 1, 0, 3'd0, 64'd3, NF, 0);
    @(negedge clk);
    chk("latency_edge1", -1, 64'(vo32), 64'd0);
    @(negedge clk);
    chk("latency_edge2", -1, 64'(vo32), 64'd1);
    drain();

    // reset with two operations in flight
    ri32 = 1'b0;
    send(0, 64'd5, 0, 1, 3'd0, 64'h40A00000, NF, 0);
    send(0, 64'd6, 0, 1, 3'd0, 64'h40C00000, NF, 0);
    chk("inflight_valid", -1, 64'(vo32), 64'd1);
    rst_n = 1'b0;
    #1;
    chk("midrst_valid", -1, 64'(vo32), 64'd0);
    chk("midrst_ready", -1, 64'(rdy32), 64'd1);
    chk("midrst_result", -1, 64'(r32), 64'd0);
    chk("midrst_flags", -1, 64'(f32), 64'd0);
    q32.delete();
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    ri32  = 1'b1;
    chk("release_ready", -1, 64'(rdy32), 64'd1);
    repeat (6) begin
      @(negedge clk);
      chk("post_rst_quiet", -1, 64'(vo32), 64'd0);
    end
    @(posedge clk);
    #1;
    send(0, 64'd7, 1, 1, 3'd0, 64'h40E00000, NF, 0);
    drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
